shifter_seq: RTL and testbench

- Iterative 16-bit shift/rotate unit for the execute stage's multi-bit shift instructions.
- Performs one single-bit step per clock until the requested amount (0-15) is consumed.
- Works in both directions: rotate left, shift left logical, shift right arithmetic, shift right logical, and rotate right.
- Uses a start/busy/done handshake, so the pipeline stalls on busy and captures the result on done.

---
 rtl/shifter_pkg.sv | 27 ++
 rtl/shift_step.sv | 28 ++
 rtl/shifter_seq.sv | 117 +++++++++++
 tb/tb_shifter_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared op codes, state encoding and widths for shifter_seq
// Purpose: single source for the operation encoding and FSM states used by
//          shifter_seq and shift_step.
// Ports:   none (package).
package shifter_pkg;

    localparam int SHIFT_WIDTH = 16;
    localparam int SHIFT_CNTW  = 4;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Codes above OP_ROR are reserved and flagged as errors.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step
// Purpose: applies one bit of the selected shift or rotate to d.
// Ports:   d  - current data word
//          op - operation code (shifter_pkg OP_*)
//          q  - data after one step; illegal codes pass d through unchanged
import shifter_pkg::*;

module shift_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
            OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
            OP_ROR:  q = {d[0], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shifter_seq.sv
// rtl/shifter_seq.sv - iterative one-bit-per-cycle shift/rotate unit
// Purpose: shifts or rotates a WIDTH-bit operand by 0..2^CNTW-1 positions,
//          one bit per clock, behind a start/busy/done handshake.
// Ports:   clk, rst_n - clock (rising edge), asynchronous active-low reset
//          start      - request, only sampled in IDLE
//          in, cnt, op - operand, shift amount, operation; captured on accept
//          busy       - high from the cycle after accept through done
//          done       - one-cycle pulse, out valid in that cycle
//          out        - result, held until the next accepted start
//          err        - illegal op flag, valid with done, cleared on next accept
import shifter_pkg::*;

module shifter_seq #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNTW-1:0]  cnt,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNTW-1:0]  rem_q,   rem_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;
    logic [WIDTH-1:0] step_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d  (data_q),
        .op (op_q),
        .q  (step_q)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d = in;
                    op_d   = op;
                    err_d  = !op_legal(op);
                    // Illegal ops and zero-length shifts skip SHIFT entirely,
                    // so the operand is returned unchanged.
                    if (!op_legal(op) || cnt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = cnt;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d = step_q;
                rem_d  = rem_q - CNTW'(1);
                if (rem_q == CNTW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so that done, busy and
        // out all change on the same edge that enters DONE.
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
        out_d  = (state_d == ST_DONE) ? data_d : out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign err  = err_q;

endmodule

// File: tb/tb_shifter_seq.sv
// tb/tb_shifter_seq.sv - directed self-checking bench for shifter_seq
module tb_shifter_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in_i;
    logic [3:0]  cnt_i;
    logic [2:0]  op_i;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        err;

    int assertions;
    int failures;

    shifter_seq #(.WIDTH(16), .CNTW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in_i),
        .cnt   (cnt_i),
        .op    (op_i),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for done. Inputs are scrambled
    // right after the accept edge so late changes would corrupt the result.
    task automatic do_op(input logic [15:0] a, input logic [3:0] c,
                         input logic [2:0] o, output int lat,
                         output int busy_cyc, output logic [15:0] res,
                         output logic e);
        lat      = 0;
        busy_cyc = 0;
        res      = 16'hxxxx;
        e        = 1'bx;
        @(negedge clk);
        in_i  = a;
        cnt_i = c;
        op_i  = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_i  = ~a;
        cnt_i = ~c;
        op_i  = o ^ 3'b011;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                lat = k;
                res = out;
                e   = err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        in_i  = 16'h0;
        cnt_i = 4'h0;
        op_i  = 3'b000;
        repeat (2) @(negedge clk);
        assertions++;
        if ({busy, done, err} !== 3'b000 || out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b err=%b out=%h, required 0 0 0 0000",
                     busy, done, err, out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rol_sra_srl;
        int lat, bc;
        logic [15:0] r;
        logic e;
        do_op(16'h8001, 4'd1, 3'b000, lat, bc, r, e);
        assertions++;
        if (lat !== 2 || r !== 16'h0003 || e !== 1'b0) begin
            failures++;
            $display("FAIL rol_1: lat=%0d out=%h err=%b, required 2 0003 0", lat, r, e);
        end
        @(negedge clk);
        assertions++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
        do_op(16'h8000, 4'd4, 3'b010, lat, bc, r, e);
        assertions++;
        if (lat !== 5 || bc !== 5 || r !== 16'hF800) begin
            failures++;
            $display("FAIL sra_4: lat=%0d busy_cycles=%0d out=%h, required 5 5 f800", lat, bc, r);
        end
        do_op(16'h8000, 4'd4, 3'b011, lat, bc, r, e);
        assertions++;
        if (lat !== 5 || r !== 16'h0800) begin
            failures++;
            $display("FAIL srl_4: lat=%0d out=%h, required 5 0800", lat, r);
        end
    endtask

    task automatic test_sll_max_ror;
        int lat, bc;
        logic [15:0] r;
        logic e;
        do_op(16'h00FF, 4'd15, 3'b001, lat, bc, r, e);
        assertions++;
        if (lat !== 16 || bc !== 16 || r !== 16'h8000) begin
            failures++;
            $display("FAIL sll_15: lat=%0d busy_cycles=%0d out=%h, required 16 16 8000", lat, bc, r);
        end
        do_op(16'h0001, 4'd1, 3'b100, lat, bc, r, e);
        assertions++;
        if (lat !== 2 || r !== 16'h8000) begin
            failures++;
            $display("FAIL ror_1: lat=%0d out=%h, required 2 8000", lat, r);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic [15:0] r;
        logic e;
        do_op(16'h1234, 4'd0, 3'b001, lat, bc, r, e);
        assertions++;
        if (lat !== 1 || bc !== 1 || r !== 16'h1234) begin
            failures++;
            $display("FAIL cnt0: lat=%0d busy_cycles=%0d out=%h, required 1 1 1234", lat, bc, r);
        end
        do_op(16'h1234, 4'd4, 3'b100, lat, bc, r, e);
        assertions++;
        if (lat !== 5 || r !== 16'h4123) begin
            failures++;
            $display("FAIL b2b_ror_4: lat=%0d out=%h, required 5 4123", lat, r);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        int extra;
        @(negedge clk);
        in_i  = 16'hA5A5;
        cnt_i = 4'd8;
        op_i  = 3'b000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        repeat (2) @(negedge clk);
        in_i  = 16'hFFFF;
        cnt_i = 4'd1;
        op_i  = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 3; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        assertions++;
        if (lat !== 9 || out !== 16'hA5A5) begin
            failures++;
            $display("FAIL ignore_start: lat=%0d out=%h, required 9 a5a5", lat, out);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        assertions++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL not_queued: active_cycles=%0d, required 0", extra);
        end
    endtask

    task automatic test_reset_mid_op;
        int seen;
        @(negedge clk);
        in_i  = 16'hA5A5;
        cnt_i = 4'd8;
        op_i  = 3'b000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        assertions++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_op: busy=%b, required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if ({busy, done, err} !== 3'b000 || out !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b err=%b out=%h, required 0 0 0 0000",
                     busy, done, err, out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        assertions++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_done: active_cycles=%0d, required 0", seen);
        end
    endtask

    task automatic test_illegal_op;
        int lat, bc;
        logic [15:0] r;
        logic e;
        do_op(16'hBEEF, 4'd5, 3'b110, lat, bc, r, e);
        assertions++;
        if (lat !== 1 || e !== 1'b1 || r !== 16'hBEEF) begin
            failures++;
            $display("FAIL illegal_op: lat=%0d err=%b out=%h, required 1 1 beef", lat, e, r);
        end
        @(negedge clk);
        assertions++;
        if (err !== 1'b1 || done !== 1'b0 || out !== 16'hBEEF) begin
            failures++;
            $display("FAIL err_held: err=%b done=%b out=%h, required 1 0 beef", err, done, out);
        end
        do_op(16'h0001, 4'd0, 3'b000, lat, bc, r, e);
        assertions++;
        if (lat !== 1 || e !== 1'b0 || r !== 16'h0001) begin
            failures++;
            $display("FAIL err_clear: lat=%0d err=%b out=%h, required 1 0 0001", lat, e, r);
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        test_reset();
        test_rol_sra_srl();
        test_sll_max_ror();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_op();
        test_illegal_op();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
